// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: shares the data RAM and the 16-bit IO bus between the CPU load/store
// path and the UART loader, with round-robin arbitration and configurable wait states.
module data_bus_arbiter #(
    parameter logic [31:0] IO_BASE     = 32'hFFFF_FC00,
    parameter int          MEM_LATENCY = 1,
    parameter int          IO_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    input  logic        uart_req,
    input  logic        uart_write,
    input  logic [31:0] uart_addr,
    input  logic [31:0] uart_wdata,
    output logic [31:0] uart_rdata,
    output logic        uart_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    output logic        io_read,
    output logic        io_write,
    input  logic [15:0] io_rdata
);
    typedef enum logic [1:0] {IDLE, MEM, IO, RESP} state_t;
    localparam logic [7:0] MEM_LAST = 8'(MEM_LATENCY - 1);
    localparam logic [7:0] IO_LAST  = 8'(IO_LATENCY - 1);

    state_t      state, next_state;
    logic        grant, last_grant, mask_cpu, mask_uart, write_q;
    logic [31:0] addr_q, wdata_q, rd_data, sel_addr;
    logic [7:0]  cnt;
    logic        req_c, req_u, pick_u, take, busy, first, last;

    // grant is 1 for the UART; on a tie the master that did not win last time goes first
    always_comb begin
        req_c    = cpu_req & ~mask_cpu;
        req_u    = uart_req & ~mask_uart;
        pick_u   = req_u & (~req_c | ~last_grant);
        take     = (state == IDLE) & (req_c | req_u);
        sel_addr = pick_u ? uart_addr : cpu_addr;
        busy     = (state == MEM) | (state == IO);
        first    = cnt == 8'd0;
        last     = cnt == ((state == MEM) ? MEM_LAST : IO_LAST);
        rd_data  = (state == MEM) ? mem_rdata : {16'h0, io_rdata};
    end

    always_ff @(posedge clk)
        state <= rst ? IDLE : next_state;

    always_comb
        next_state = (state == IDLE) ? (take ? ((sel_addr < IO_BASE) ? MEM : IO) : IDLE)
                   : busy ? (last ? RESP : state)
                   : IDLE;

    always_comb begin
        cpu_ack   = (state == RESP) & ~grant;
        uart_ack  = (state == RESP) & grant;
        cpu_stall = cpu_req & ~cpu_ack;
        mem_addr  = (state == MEM) ? addr_q : '0;
        mem_wdata = (state == MEM) ? wdata_q : '0;
        mem_we    = (state == MEM) & first & write_q;
        io_addr   = (state == IO) ? addr_q : '0;
        io_wdata  = (state == IO) ? wdata_q : '0;
        io_read   = (state == IO) & first & ~write_q;
        io_write  = (state == IO) & first & write_q;
    end

    // the mask hides a master's still-high req in the IDLE cycle right after its ack
    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            mask_cpu   <= 1'b0;
            mask_uart  <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt        <= '0;
            cpu_rdata  <= '0;
            uart_rdata <= '0;
        end else begin
            mask_cpu  <= (state == RESP) & ~grant;
            mask_uart <= (state == RESP) & grant;
            cnt       <= (busy & ~last) ? cnt + 8'd1 : 8'd0;
            if (take) begin
                grant      <= pick_u;
                last_grant <= pick_u;
                addr_q     <= sel_addr;
                write_q    <= pick_u ? uart_write : cpu_write;
                wdata_q    <= pick_u ? uart_wdata : cpu_wdata;
            end
            if (busy & last & ~write_q & grant)
                uart_rdata <= rd_data;
            if (busy & last & ~write_q & ~grant)
                cpu_rdata <= rd_data;
        end
    end
endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter: directed and random traffic from both masters, checked every cycle
// against a transaction-level model built from grant/ack timestamps.
module tb_data_bus_arbiter;
    localparam logic [31:0] IO_BASE = 32'hFFFF_FC00;
    localparam int ML = 3;
    localparam int IL = 1;

    logic        clk = 0, rst = 1;
    logic        cpu_req = 0, cpu_write = 0, uart_req = 0, uart_write = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, uart_addr = 0, uart_wdata = 0;
    logic [31:0] cpu_rdata, uart_rdata, mem_addr, mem_wdata, io_addr, io_wdata;
    logic        cpu_ack, cpu_stall, uart_ack, mem_we, io_read, io_write;
    logic [31:0] mem_rdata = 0;
    logic [15:0] io_rdata = 0;

    int checks = 0, errors = 0;

    data_bus_arbiter #(.IO_BASE(IO_BASE), .MEM_LATENCY(ML), .IO_LATENCY(IL)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .uart_req(uart_req), .uart_write(uart_write), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
        .uart_rdata(uart_rdata), .uart_ack(uart_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_read(io_read), .io_write(io_write),
        .io_rdata(io_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // environment: RAM with ML cycles of read latency (two-stage address delay), IO echoes a hash
    logic [31:0] ram [logic [31:0]];
    logic [31:0] ref_ram [logic [31:0]];
    logic [31:0] hist [2] = '{32'h0, 32'h0};

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction
    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_val(a);
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_ram.exists(a) ? ref_ram[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] = mem_wdata;
        hist[1] <= hist[0];
        hist[0] <= mem_addr;
    end
    always @(negedge clk) begin
        mem_rdata <= env_rd(hist[1]);
        io_rdata  <= io_addr[15:0] ^ 16'h59D5;
    end

    // reference model: one transaction at a time, described by its grant and ack cycles
    int          cyc = 0, gnt_t = 0, ack_t = 0, mask_t = -10;
    bit          busy = 0, who = 0, lg = 1, mask_who = 0, t_wr = 0, t_mem = 0;
    logic [31:0] t_addr = 0, t_wdata = 0, t_val = 0;
    logic [31:0] exp_rd [2] = '{32'h0, 32'h0};

    always @(negedge clk) begin
        bit first, ea_c, ea_u, rc, ru;
        cyc++;
        first = busy && cyc == gnt_t + 1;
        ea_c  = busy && cyc == ack_t && !who;
        ea_u  = busy && cyc == ack_t && who;
        if ((ea_c || ea_u) && !t_wr) exp_rd[who] = t_val;
        check("cpu_ack", 32'(cpu_ack), 32'(ea_c));
        check("uart_ack", 32'(uart_ack), 32'(ea_u));
        check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !ea_c));
        check("cpu_rdata", cpu_rdata, exp_rd[0]);
        check("uart_rdata", uart_rdata, exp_rd[1]);
        check("mem_we", 32'(mem_we), 32'(first && t_mem && t_wr));
        check("io_read", 32'(io_read), 32'(first && !t_mem && !t_wr));
        check("io_write", 32'(io_write), 32'(first && !t_mem && t_wr));
        if (first && t_mem) begin
            check("mem_addr", mem_addr, t_addr);
            if (t_wr) begin
                check("mem_wdata", mem_wdata, t_wdata);
                ref_ram[t_addr] = t_wdata;
            end
        end
        if (first && !t_mem) begin
            check("io_addr", io_addr, t_addr);
            if (t_wr) check("io_wdata", io_wdata, t_wdata);
        end
        if (rst) begin
            busy = 0; lg = 1; mask_t = -10; exp_rd = '{32'h0, 32'h0};
        end else if (busy) begin
            if (cyc == ack_t) begin
                busy = 0; mask_t = cyc + 1; mask_who = who;
            end
        end else begin
            rc = cpu_req && !(mask_t == cyc && !mask_who);
            ru = uart_req && !(mask_t == cyc && mask_who);
            if (rc || ru) begin
                who     = (rc && ru) ? !lg : ru;
                lg      = who;
                busy    = 1;
                gnt_t   = cyc;
                t_addr  = who ? uart_addr : cpu_addr;
                t_wdata = who ? uart_wdata : cpu_wdata;
                t_wr    = who ? uart_write : cpu_write;
                t_mem   = t_addr < IO_BASE;
                ack_t   = cyc + 1 + (t_mem ? ML : IL);
                t_val   = t_mem ? ref_rd(t_addr) : {16'h0, t_addr[15:0] ^ 16'h59D5};
            end
        end
    end

    // stimulus
    logic [31:0] edge_addr [3] = '{IO_BASE - 32'd1, IO_BASE, 32'hFFFF_FFFF};

    task automatic step();
        @(posedge clk); #1;
    endtask
    task automatic set_req(input bit m, input bit w, input logic [31:0] a, input logic [31:0] d);
        if (m) begin uart_req = 1; uart_write = w; uart_addr = a; uart_wdata = d; end
        else begin cpu_req = 1; cpu_write = w; cpu_addr = a; cpu_wdata = d; end
    endtask
    task automatic drop(input bit m);
        if (m) uart_req = 0; else cpu_req = 0;
    endtask
    task automatic wait_ack(input bit m, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!(m ? uart_ack : cpu_ack) && n < 40);
        check("ack_seen", 32'(m ? uart_ack : cpu_ack), 32'd1);
    endtask
    task automatic access(input bit m, input bit w, input logic [31:0] a, input logic [31:0] d, output int n);
        set_req(m, w, a, d);
        wait_ack(m, n);
        step(); drop(m); step();
    endtask
    task automatic rand_req(input bit m);
        logic [31:0] a;
        int r;
        r = $urandom_range(0, 9);
        a = r < 5 ? 32'($urandom_range(0, 255)) << 2
          : r < 9 ? IO_BASE + (32'($urandom_range(0, 255)) << 2)
          : edge_addr[$urandom_range(0, 2)];
        set_req(m, 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    initial begin
        int n, k;
        bit ac, au, act, ackd, w;
        ram[32'h10] = 32'hDEAD_BEEF;
        ref_ram[32'h10] = 32'hDEAD_BEEF;
        repeat (3) step();
        rst = 0; step();
        // CPU load from RAM, store to RAM, load from IO
        set_req(0, 0, 32'h10, 0); wait_ack(0, n);
        check("cpu_mem_latency", 32'(n), 32'(ML + 2));
        check("cpu_load_data", cpu_rdata, 32'hDEAD_BEEF);
        step(); drop(0); step();
        access(0, 1, 32'h20, 32'h1234_5678, n);
        check("cpu_store_latency", 32'(n), 32'(ML + 2));
        check("store_keeps_rdata", cpu_rdata, 32'hDEAD_BEEF);
        set_req(0, 0, 32'hFFFF_FC70, 0); wait_ack(0, n);
        check("cpu_io_latency", 32'(n), 32'(IL + 2));
        check("cpu_io_data", cpu_rdata, 32'h0000_A5A5);
        step(); drop(0); step();
        // simultaneous requests right after reset, both held: CPU first, then alternating
        rst = 1; step(); step();
        rst = 0;
        set_req(0, 0, 32'hFFFF_FC10, 0);
        set_req(1, 0, 32'hFFFF_FC20, 0);
        for (k = 0; k < 6; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!(cpu_ack || uart_ack) && n < 40);
            check("any_ack", 32'(cpu_ack || uart_ack), 32'd1);
            check("grant_order", 32'(uart_ack), 32'(k % 2));
            w = uart_ack;
            step();
            set_req(w, 1'(k % 3 == 0), IO_BASE + 32'(k * 8), $urandom);
        end
        drop(0); drop(1);
        repeat (8) step();
        // reset in the second MEM cycle of a store aborts it without an ack
        set_req(0, 1, 32'h40, 32'hCAFE_F00D);
        step(); step();
        rst = 1; step();
        rst = 0; drop(0);
        check("reset_no_ack", 32'(cpu_ack), 32'd0);
        step();
        access(0, 0, 32'h44, 0, n);
        check("after_reset_latency", 32'(n), 32'(ML + 2));
        // UART read from RAM with three wait states
        access(1, 0, 32'h100, 0, n);
        check("uart_mem_latency", 32'(n), 32'(ML + 2));
        // request dropped right after the grant still completes
        set_req(0, 0, 32'h80, 0); step(); drop(0);
        wait_ack(0, n);
        check("dropped_req_latency", 32'(n), 32'(ML + 1));
        step(); step();
        // decode boundaries
        access(1, 1, IO_BASE - 32'd1, 32'h0BAD_CAFE, n);
        check("below_io_base", 32'(n), 32'(ML + 2));
        access(1, 0, IO_BASE, 0, n);
        check("at_io_base", 32'(n), 32'(IL + 2));
        access(0, 0, 32'hFFFF_FFFF, 0, n);
        check("top_address", 32'(n), 32'(IL + 2));
        // random traffic from both masters
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ac = cpu_ack; au = uart_ack;
            step();
            for (int m = 0; m < 2; m++) begin
                act  = m ? uart_req : cpu_req;
                ackd = m ? au : ac;
                if (act && ackd) begin
                    if ($urandom_range(0, 1) == 1) rand_req(1'(m)); else drop(1'(m));
                end else if (!act && $urandom_range(0, 3) == 0) rand_req(1'(m));
            end
        end
        drop(0); drop(1);
        repeat (10) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end
endmodule
